// File: rtl/bcd_run_counter.sv
// Multi-digit BCD run counter with prescaler, multi-press clear, preset load
// and wrap/saturate behaviour at all-nines.
module bcd_run_counter #(
    parameter int DIGITS        = 2,
    parameter int PRESCALE      = 1,
    parameter int CLEAR_PRESSES = 2,
    parameter int SAT_MODE      = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                allow_start,
    input  logic                stop,
    input  logic                over,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                change,
    output logic                wrap,
    output logic                full,
    output logic                armed
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int NW = (CLEAR_PRESSES > 1) ? $clog2(CLEAR_PRESSES) : 1;

    localparam logic [CW-1:0] ALL_NINES  = {DIGITS{4'h9}};
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [NW-1:0] PRESS_LAST = NW'(CLEAR_PRESSES - 1);

    logic [CW-1:0] count_q,   count_d;
    logic [PW-1:0] pre_q,     pre_d;
    logic [NW-1:0] presses_q, presses_d;
    logic          change_q,  change_d;
    logic          wrap_q,    wrap_d;

    logic run, clr;

    // Ripple-carry increment; a digit at 9 rolls to 0 and passes the carry up.
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    assign run = start & allow_start & ~stop & ~over;
    assign clr = start & allow_start &  stop & ~over;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        count_d   = count_q;
        pre_d     = pre_q;
        presses_d = presses_q;
        change_d  = 1'b0;
        wrap_d    = 1'b0;

        if (load) begin
            count_d   = bcd_clamp(load_val);
            pre_d     = '0;
            presses_d = '0;
        end else if (clr) begin
            if (presses_q == PRESS_LAST) begin
                count_d   = '0;
                pre_d     = '0;
                presses_d = '0;
                change_d  = 1'b1;
            end else begin
                presses_d = presses_q + NW'(1);
            end
        end else if (run) begin
            if (pre_q != PRE_LAST) begin
                pre_d = pre_q + PW'(1);
            end else if (count_q != ALL_NINES) begin
                count_d = bcd_inc(count_q);
                pre_d   = '0;
            end else if (SAT_MODE == 0) begin
                count_d = '0;
                pre_d   = '0;
                wrap_d  = 1'b1;
            end
            // Saturating at all-nines: count and prescaler simply hold.
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            pre_q     <= '0;
            presses_q <= '0;
            change_q  <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pre_q     <= pre_d;
            presses_q <= presses_d;
            change_q  <= change_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count  = count_q;
    assign change = change_q;
    assign wrap   = wrap_q;
    assign full   = (count_q == ALL_NINES);
    assign armed  = (presses_q != '0);

endmodule

// File: tb/tb_bcd_run_counter.sv
// Directed bench for bcd_run_counter: three instances (default, PRESCALE=3,
// SAT_MODE=1) share one stimulus stream; expected values are hand-computed.
module tb_bcd_run_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, allow_start, stop, over, load;
    logic [7:0] load_val;

    logic [7:0] count_a, count_b, count_c;
    logic       change_a, wrap_a, full_a, armed_a;
    logic       change_b, wrap_b, full_b, armed_b;
    logic       change_c, wrap_c, full_c, armed_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_run_counter #(.DIGITS(2), .PRESCALE(1), .CLEAR_PRESSES(2), .SAT_MODE(0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .allow_start(allow_start),
        .stop(stop), .over(over), .load(load), .load_val(load_val),
        .count(count_a), .change(change_a), .wrap(wrap_a), .full(full_a), .armed(armed_a)
    );

    bcd_run_counter #(.DIGITS(2), .PRESCALE(3), .CLEAR_PRESSES(2), .SAT_MODE(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .allow_start(allow_start),
        .stop(stop), .over(over), .load(load), .load_val(load_val),
        .count(count_b), .change(change_b), .wrap(wrap_b), .full(full_b), .armed(armed_b)
    );

    bcd_run_counter #(.DIGITS(2), .PRESCALE(1), .CLEAR_PRESSES(2), .SAT_MODE(1)) u_dut_c (
        .clk(clk), .reset(reset), .start(start), .allow_start(allow_start),
        .stop(stop), .over(over), .load(load), .load_val(load_val),
        .count(count_c), .change(change_c), .wrap(wrap_c), .full(full_c), .armed(armed_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        start = 1'b0; stop = 1'b0; load = 1'b1; load_val = v;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; allow_start = 1'b0; stop = 1'b0;
        over = 1'b0; load = 1'b0; load_val = 8'h00;
        #3;
        check("rst_count", count_a, 8'h00);
        check("rst_full",  full_a,  1'b0);
        check("rst_armed", armed_a, 1'b0);
        check("rst_change", change_a, 1'b0);
        check("rst_wrap",  wrap_a,  1'b0);
        reset = 1'b0;
        step(1);
        check("idle_hold", count_a, 8'h00);

        // V1: 23 run cycles at PRESCALE=1
        start = 1'b1; allow_start = 1'b1;
        for (int i = 0; i < 23; i++) begin
            step(1);
            check("v1_change", change_a, 1'b0);
        end
        check("v1_count", count_a, 8'h23);
        check("v1_full",  full_a,  1'b0);

        // V2: 9 run cycles at PRESCALE=3 from a fresh reset
        pulse_reset();
        check("v2_rst_b", count_b, 8'h00);
        step(9);
        check("v2_count_b", count_b, 8'h03);
        check("v2_count_a", count_a, 8'h09);

        // V3: wrap from 99 (SAT_MODE=0), hold at 99 (SAT_MODE=1)
        do_load(8'h99);
        check("v3_load", count_a, 8'h99);
        check("v3_full", full_a,  1'b1);
        start = 1'b1;
        step(1);
        check("v3_count", count_a, 8'h00);
        check("v3_wrap",  wrap_a,  1'b1);
        check("v3_full0", full_a,  1'b0);
        check("v3_sat_count", count_c, 8'h99);
        check("v3_sat_wrap",  wrap_c,  1'b0);
        start = 1'b0;
        step(1);
        check("v3_wrap_once", wrap_a, 1'b0);
        check("v3_hold", count_a, 8'h00);

        // V4: 5 run cycles while saturated
        do_load(8'h99);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("v4_wrap", wrap_c, 1'b0);
        end
        check("v4_count", count_c, 8'h99);
        check("v4_full",  full_c,  1'b1);

        // V5: two-press clear with runs in between
        do_load(8'h42);
        check("v5_armed0", armed_a, 1'b0);
        start = 1'b1; stop = 1'b1;
        step(1);
        check("v5_armed1", armed_a, 1'b1);
        check("v5_count1", count_a, 8'h42);
        check("v5_change1", change_a, 1'b0);
        stop = 1'b0;
        step(3);
        check("v5_count2", count_a, 8'h45);
        check("v5_armed2", armed_a, 1'b1);
        stop = 1'b1;
        step(1);
        check("v5_count3", count_a, 8'h00);
        check("v5_change3", change_a, 1'b1);
        check("v5_armed3", armed_a, 1'b0);
        start = 1'b0; stop = 1'b0;
        step(1);
        check("v5_change_once", change_a, 1'b0);

        // V6: freeze, asynchronous reset, clamped load
        do_load(8'h17);
        start = 1'b1; stop = 1'b1;
        step(1);
        check("v6_armed", armed_a, 1'b1);
        over = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start       = i[0];
            stop        = i[1];
            allow_start = ~i[2];
            step(1);
            check("v6_over_count", count_a, 8'h17);
            check("v6_over_armed", armed_a, 1'b1);
            check("v6_over_change", change_a, 1'b0);
        end
        over = 1'b0; start = 1'b1; allow_start = 1'b1; stop = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("v6_rst_count", count_a, 8'h00);
        check("v6_rst_armed", armed_a, 1'b0);
        check("v6_rst_full",  full_a,  1'b0);
        check("v6_rst_change", change_a, 1'b0);
        check("v6_rst_wrap",  wrap_a,  1'b0);
        reset = 1'b0;
        do_load(8'hA5);
        check("v6_load_clamp", count_a, 8'h95);
        do_load(8'h3C);
        check("load_clamp_lo", count_a, 8'h39);

        // Reset discards prescaler progress: 2 runs, reset, 2 runs -> still 0 at PRESCALE=3
        pulse_reset();
        start = 1'b1; allow_start = 1'b1;
        step(2);
        pulse_reset();
        step(2);
        check("rst_pre_discard", count_b, 8'h00);
        step(1);
        check("pre_after_rst", count_b, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_run_counter.md
BCD_RUN_COUNTER -- requirements
Module: bcd_run_counter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DIGITS, 2: number of BCD digits, legal 1..8.
- PRESCALE, 1: qualifying run cycles per count increment, legal 1..1024.
- CLEAR_PRESSES, 2: qualifying stop cycles needed to clear, legal 1..4.
- SAT_MODE, 0: 0 = wrap at all-nines, 1 = saturate at all-nines.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high; clears all state immediately.
- start, in, 1: run request.
- allow_start, in, 1: run/clear permission gate.
- stop, in, 1: selects a clear press instead of counting.
- over, in, 1: freeze; blocks counting and clear presses.
- load, in, 1: synchronous preset strobe.
- load_val, in, 4*DIGITS: preset value; digit 0 is bits [3:0] (least significant).
- count, out, 4*DIGITS: registered BCD value; digit 0 is bits [3:0].
- change, out, 1: one-cycle pulse on the cycle a clear executes.
- wrap, out, 1: one-cycle pulse when the count rolls from all-nines to zero.
- full, out, 1: high while count equals all-nines.
- armed, out, 1: high while at least one clear press is pending.

Function
REQ-003 Qualifiers SHALL be:
- run = start & allow_start & !stop & !over
- clr = start & allow_start & stop & !over

REQ-004 Priority per cycle SHALL be load, then clr, then run, then idle (hold).

REQ-005 The prescaler SHALL be a counter pre of width clog2(PRESCALE), minimum 1 bit:
- on each run cycle: if pre == PRESCALE-1, pre <= 0 and the count increments; otherwise pre <= pre+1;
- with PRESCALE=1 every run cycle increments the count.

REQ-006 A count increment SHALL ripple-carry in BCD:
- digit 0 increments;
- a digit at 9 becomes 0 and carries into the next digit;
- no digit may ever hold a value above 9.

REQ-007 Increment from all-nines with SAT_MODE=0: count <= 0 and wrap=1 for that cycle.

REQ-008 Increment from all-nines with SAT_MODE=1: count and pre hold, and wrap stays 0.

REQ-009 full SHALL equal (count == all-nines), derived from the count register, in both modes.

REQ-010 A press counter presses (0..CLEAR_PRESSES-1) SHALL track clear presses:
- on a clr cycle with presses < CLEAR_PRESSES-1: presses increments and count is unchanged;
- on a clr cycle with presses == CLEAR_PRESSES-1: count <= 0, pre <= 0, presses <= 0, change=1 that cycle;
- with CLEAR_PRESSES=1 every clr cycle clears.

REQ-011 presses SHALL persist across idle and run cycles; only a clear, a load or reset returns it to 0.

REQ-012 armed SHALL equal (presses != 0).

REQ-013 On a load cycle:
- count <= load_val, with any digit above 9 clamped to 9;
- pre <= 0 and presses <= 0;
- change and wrap stay 0.

REQ-014 change and wrap SHALL be registered and SHALL be 0 on every cycle not named in REQ-007 or REQ-010.

REQ-015 While over=1 and load=0, all state SHALL hold regardless of start, stop and allow_start.

REQ-016 Each output SHALL reflect its cycle's update one clock after the qualifying edge; no combinational path from inputs to outputs is permitted.

Reset
REQ-017 On reset=1, asynchronously: count=0, pre=0, presses=0, change=0, wrap=0, full=0, armed=0.

REQ-018 Reset asserted mid-count or mid-clear-sequence SHALL discard all pending presses and prescaler progress.

REQ-019 After reset deasserts, the first clk edge SHALL be evaluated normally; no initialisation cycle is inserted.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- V1, DIGITS=2, PRESCALE=1, run for 23 cycles -> count=8'h23, full=0, change=0 throughout.
- V2, DIGITS=2, PRESCALE=3, 9 run cycles -> count=8'h03.
- V3, DIGITS=2, SAT_MODE=0, load 8'h99 then 1 run cycle -> count=8'h00, wrap=1 for exactly one cycle.
- V4, DIGITS=2, SAT_MODE=1, load 8'h99 then 5 run cycles -> count=8'h99, full=1, wrap=0 throughout.
- V5, CLEAR_PRESSES=2, count=8'h42:
  - one clr cycle -> armed=1, count=8'h42;
  - 3 run cycles -> count=8'h45, armed=1;
  - one clr cycle -> count=8'h00, change=1 for one cycle, armed=0.
- V6, count 8'h17 with armed=1:
  - over=1 with start/stop toggling for 10 cycles -> no change;
  - assert reset mid-cycle -> all outputs 0 immediately;
  - load 8'hA5 -> count=8'h95.
